ext_msg_rw_ctrl: RTL and testbench
==================================

Name: ext_msg_rw_ctrl

Overview:
- Sequencer that reads and writes the extrinsic-message RAM, which is single-port with synchronous read and write.
- For each edge in a pass: reads the stored message, hands it to the node-processing unit over a valid/ready channel, accepts the updated message back, and writes it to the same address.
- Repeats for NUM_ITER passes per start.
- Sits between the ext RAM and the check/variable node processors in the LDPC decoder datapath.

Parameters:
- DATA_WIDTH, 5, extrinsic message width in bits.
- ADDR_WIDTH, 8, RAM address width.
- NUM_EDGES, 256, edges per pass; 1 <= NUM_EDGES <= 2^ADDR_WIDTH.
- BASE_ADDR, 0, address of edge 0; edge e maps to (BASE_ADDR + e) mod 2^ADDR_WIDTH.
- NUM_ITER, 4, passes per start; >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a run when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final write of the final pass.
- iter  out  $clog2(NUM_ITER+1)  index of the current pass, 0-based.
- edge_idx  out  ADDR_WIDTH  current edge index, 0..NUM_EDGES-1.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM read data; valid the cycle after a read.
- msg_out  out  DATA_WIDTH  stored message sent to the processor.
- msg_out_valid  out  1  msg_out is valid.
- msg_out_ready  in  1  processor accepts msg_out.
- msg_in  in  DATA_WIDTH  updated message from the processor.
- msg_in_valid  in  1  msg_in is valid.
- msg_in_ready  out  1  controller accepts msg_in.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, ram_cs, ram_we, msg_out_valid and msg_in_ready are all 0.
  - msg_out, ram_data_in, ram_address, edge_idx and iter are all 0.
- FSM states: IDLE, RD, CAP, OUT, IN, WR, DONE.
- IDLE:
  - start=1 clears edge_idx and iter, then moves to RD.
  - start while not in IDLE is ignored.
- RD (1 cycle): ram_cs=1, ram_we=0, ram_address=BASE_ADDR+edge_idx; moves to CAP.
- CAP (1 cycle): msg_out <= ram_data_out; moves to OUT.
- OUT:
  - msg_out_valid=1.
  - Transfers when msg_out_valid & msg_out_ready, then moves to IN.
  - msg_out is held stable while valid.
- IN:
  - msg_in_ready=1.
  - Transfers when msg_in_valid & msg_in_ready: ram_data_in <= msg_in, then moves to WR.
- WR (1 cycle): ram_cs=1, ram_we=1, same address as the preceding RD.
  - If edge_idx < NUM_EDGES-1: edge_idx+1, go to RD.
  - Else if iter < NUM_ITER-1: edge_idx=0, iter+1, go to RD.
  - Else go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. iter and edge_idx hold their final values until the next start.
- ram_cs=0 in every state other than RD and WR. ram_address holds its last value.
- Latency and throughput:
  - Minimum 5 cycles per edge (RD, CAP, OUT, IN, WR) when the processor is always ready/valid.
  - A run takes NUM_EDGES*NUM_ITER*5 + 1 cycles from start to done, with zero stalls.
- Handshake edge cases:
  - msg_out_ready asserted outside OUT is ignored.
  - msg_in_valid asserted outside IN is ignored; it does not pre-load data.
- Address wrap: BASE_ADDR+edge_idx is truncated to ADDR_WIDTH bits.
- rst mid-run returns to IDLE immediately and abandons the run. An in-flight WR is not issued if rst is sampled high in that cycle.

Optional Feature:
- Macro: EXT_INIT_EN.
- With the macro defined:
  - Adds input port init, 1 bit.
  - start with init=1 runs a single clear pass of NUM_EDGES consecutive cycles in a dedicated state CLR.
  - Each cycle writes 0 to BASE_ADDR+edge_idx with ram_cs=1, ram_we=1. No processor handshake takes place.
  - Then DONE. iter stays 0.
  - start with init=0 behaves as normal.
- Without the macro: the init port and CLR state are absent, and start always runs normal passes.

Test Plan:
- NUM_EDGES=4, NUM_ITER=1, RAM preloaded with 1,2,3,4; processor always ready and returns msg+1 -> msg_out sequence is 1,2,3,4; RAM ends 2,3,4,5; done pulses exactly 21 cycles after start.
- Same setup, NUM_ITER=3 -> iter steps 0,1,2; RAM ends 4,5,6,7; exactly one done pulse.
- msg_out_ready held low 7 cycles, and msg_in_valid delayed 3 cycles -> msg_out stays stable with valid high throughout; no RAM access during stalls; final data is correct.
- BASE_ADDR=254, NUM_EDGES=4, ADDR_WIDTH=8 -> addresses 254,255,0,1, with the RAM write at each matching its read.
- rst asserted in the IN state of edge 2 -> next cycle all outputs are at reset values and no write to edge 2 occurs; a subsequent start restarts from edge 0, iter 0.
- EXT_INIT_EN defined, start with init=1, NUM_EDGES=4 -> 4 consecutive write cycles of 0, no msg_out_valid, done on the 5th cycle after start.

Source files
------------

// File: rtl/ext_msg_rw_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ext_msg_rw_ctrl_if
//  Description : Bundles the extrinsic-message RAM port and the two
//                valid/ready channels to and from the node processor.
//                master = sequencer side, slave = RAM / processor side.
//  Signals     : ram_address, ram_cs, ram_we, ram_data_in, ram_data_out,
//                msg_out, msg_out_valid, msg_out_ready,
//                msg_in, msg_in_valid, msg_in_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface ext_msg_rw_ctrl_if #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_cs;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic [DATA_WIDTH-1:0] msg_out;
    logic                  msg_out_valid;
    logic                  msg_out_ready;
    logic [DATA_WIDTH-1:0] msg_in;
    logic                  msg_in_valid;
    logic                  msg_in_ready;

    modport master (
        output ram_address, ram_cs, ram_we, ram_data_in,
        input  ram_data_out,
        output msg_out, msg_out_valid,
        input  msg_out_ready,
        input  msg_in, msg_in_valid,
        output msg_in_ready
    );

    modport slave (
        input  ram_address, ram_cs, ram_we, ram_data_in,
        output ram_data_out,
        input  msg_out, msg_out_valid,
        output msg_out_ready,
        output msg_in, msg_in_valid,
        input  msg_in_ready
    );
endinterface
`default_nettype wire

// File: rtl/ext_msg_rw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ext_msg_rw_ctrl
//  Description : Extrinsic-message RAM sequencer. For every edge of a pass it
//                reads the stored message, hands it to the node processor,
//                takes the updated message back and writes it to the same
//                address. NUM_ITER passes are run per start.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start_i            - begin a run (ignored unless idle)
//                init_i             - (EXT_INIT_EN only) run a clear pass
//                busy_o / done_o    - run in progress / one-cycle completion
//                iter_o, edge_idx_o - current pass and edge index
//                bus (master)       - RAM port and processor channels
//  Options     : `define EXT_INIT_EN adds init_i and the CLR state, which
//                writes zero to every edge address in one sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_msg_rw_ctrl #(
    parameter  int DATA_WIDTH = 5,
    parameter  int ADDR_WIDTH = 8,
    parameter  int NUM_EDGES  = 256,
    parameter  int BASE_ADDR  = 0,
    parameter  int NUM_ITER   = 4,
    localparam int ITER_WIDTH = $clog2(NUM_ITER + 1)
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start_i,
`ifdef EXT_INIT_EN
    input  wire                   init_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ITER_WIDTH-1:0] iter_o,
    output logic [ADDR_WIDTH-1:0] edge_idx_o,
    ext_msg_rw_ctrl_if.master     bus
);

    localparam logic [ADDR_WIDTH-1:0] c_base      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_last_edge = ADDR_WIDTH'(NUM_EDGES - 1);
    localparam logic [ITER_WIDTH-1:0] c_last_iter = ITER_WIDTH'(NUM_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_IN   = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
`ifdef EXT_INIT_EN
        , S_CLR = 3'd7
`endif
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] edge_q,    edge_d;
    logic [ITER_WIDTH-1:0] iter_q,    iter_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] msg_out_q, msg_out_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

    logic [ADDR_WIDTH-1:0] edge_inc_w;
    logic                  rd_cycle_w;
    logic                  wr_cycle_w;

    assign edge_inc_w = edge_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            iter_q    <= '0;
            addr_q    <= '0;
            msg_out_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            iter_q    <= iter_d;
            addr_q    <= addr_d;
            msg_out_q <= msg_out_d;
            wdata_q   <= wdata_d;
        end
    end

    // The address register is loaded on the transition into RD/CLR, so it
    // already points at the current edge during RD and is still unchanged
    // for the matching WR. Outside RD/WR/CLR it simply holds.
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        iter_d    = iter_q;
        addr_d    = addr_q;
        msg_out_d = msg_out_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    edge_d = '0;
                    iter_d = '0;
                    addr_d = c_base;
`ifdef EXT_INIT_EN
                    if (init_i) begin
                        wdata_d = '0;
                        state_d = S_CLR;
                    end else begin
                        state_d = S_RD;
                    end
`else
                    state_d = S_RD;
`endif
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                msg_out_d = bus.ram_data_out;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (bus.msg_out_ready) state_d = S_IN;
            end
            S_IN: begin
                if (bus.msg_in_valid) begin
                    wdata_d = bus.msg_in;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (edge_q < c_last_edge) begin
                    edge_d  = edge_inc_w;
                    addr_d  = c_base + edge_inc_w;
                    state_d = S_RD;
                end else if (iter_q < c_last_iter) begin
                    edge_d  = '0;
                    iter_d  = iter_q + ITER_WIDTH'(1);
                    addr_d  = c_base;
                    state_d = S_RD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef EXT_INIT_EN
            // One zero write per cycle; wdata_q was cleared on entry.
            S_CLR: begin
                if (edge_q < c_last_edge) begin
                    edge_d = edge_inc_w;
                    addr_d = c_base + edge_inc_w;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cycle_w = (state_q == S_RD);
`ifdef EXT_INIT_EN
        wr_cycle_w = (state_q == S_WR) || (state_q == S_CLR);
`else
        wr_cycle_w = (state_q == S_WR);
`endif
    end

    // Gating with rst keeps a write from reaching the RAM in the same cycle
    // that reset is sampled, so an interrupted edge is never half-committed.
    assign bus.ram_cs        = (rd_cycle_w || wr_cycle_w) && !rst;
    assign bus.ram_we        = wr_cycle_w && !rst;
    assign bus.ram_address   = addr_q;
    assign bus.ram_data_in   = wdata_q;
    assign bus.msg_out       = msg_out_q;
    assign bus.msg_out_valid = (state_q == S_OUT);
    assign bus.msg_in_ready  = (state_q == S_IN);

    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o     = (state_q == S_DONE);
    assign iter_o     = iter_q;
    assign edge_idx_o = edge_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_msg_rw_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ext_msg_rw_ctrl
//  Description : Self-checking bench for ext_msg_rw_ctrl with a RAM model,
//                a randomised processor model and a pass-level reference.
//                Build with +define+EXT_INIT_EN to include the clear pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_msg_rw_ctrl;
    localparam int DW   = 5;
    localparam int AW   = 8;
    localparam int NE   = 4;
    localparam int BASE = 254;
    localparam int NI   = 3;
    localparam int IW   = $clog2(NI + 1);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
`ifdef EXT_INIT_EN
    logic init  = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic [IW-1:0] iter;
    logic [AW-1:0] edge_idx;

    int n_checks = 0;
    int n_fail   = 0;

    ext_msg_rw_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ext_msg_rw_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_EDGES(NE),
        .BASE_ADDR(BASE), .NUM_ITER(NI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
`ifdef EXT_INIT_EN
        .init_i     (init),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .iter_o     (iter),
        .edge_idx_o (edge_idx),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model and bus monitor ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    acc_t          log_q [$];
    logic [DW-1:0] out_q [$];
    int            iter_q [$];
    int            done_cnt  = 0;
    int            valid_cnt = 0;
    int            stab_err  = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_msg  = '0;

    always @(posedge clk) begin
        if (bus.ram_cs) begin
            log_q.push_back({bus.ram_we, bus.ram_address, bus.ram_data_in});
            if (bus.ram_we) mem[bus.ram_address] <= bus.ram_data_in;
            else            bus.ram_data_out    <= mem[bus.ram_address];
        end
        if (done) done_cnt <= done_cnt + 1;
        if (bus.msg_out_valid) valid_cnt <= valid_cnt + 1;
        if (hold_pend && bus.msg_out_valid && bus.msg_out !== hold_msg) stab_err <= stab_err + 1;
        hold_pend <= bus.msg_out_valid && !bus.msg_out_ready;
        hold_msg  <= bus.msg_out;
        if (bus.msg_out_valid && bus.msg_out_ready) begin
            out_q.push_back(bus.msg_out);
            iter_q.push_back(int'(iter));
        end
    end

    // ---------------- processor model: returns msg+1 ----------------
    int   p_rdy = 100;
    int   p_val = 100;
    bit   fixed = 1'b0;
    int   rdly  = 0;
    int   vdly  = 0;
    logic [DW-1:0] pend;

    initial begin
        int ow;
        int iw;
        ow = 0; iw = 0; pend = '0;
        bus.msg_out_ready = 1'b0;
        bus.msg_in_valid  = 1'b0;
        bus.msg_in        = '0;
        forever begin
            @(negedge clk);
            ow = bus.msg_out_valid ? ow + 1 : 0;
            iw = bus.msg_in_ready  ? iw + 1 : 0;
            bus.msg_out_ready = fixed ? (bus.msg_out_valid && ow > rdly)
                                      : ($urandom_range(99) < p_rdy);
            if (bus.msg_out_valid && bus.msg_out_ready) pend = bus.msg_out + 5'd1;
            bus.msg_in       = bus.msg_in_ready ? pend : DW'($urandom);
            bus.msg_in_valid = fixed ? (bus.msg_in_ready && iw > vdly)
                                     : ($urandom_range(99) < p_val);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] model_v [NE];
    acc_t          exp_log [$];
    logic [DW-1:0] exp_out [$];
    int            exp_iter [$];

    function automatic logic [AW-1:0] ea(input int e);
        return AW'((BASE + e) % (1 << AW));
    endfunction

    task automatic preload();
        for (int e = 0; e < NE; e++) begin
            model_v[e] = DW'($urandom);
            mem[ea(e)] <= model_v[e];
        end
    endtask

    // Every pass reads each edge in order, sends it, and writes back msg+1.
    task automatic build_expect();
        acc_t r;
        exp_log.delete(); exp_out.delete(); exp_iter.delete();
        for (int it = 0; it < NI; it++) begin
            for (int e = 0; e < NE; e++) begin
                exp_out.push_back(model_v[e]);
                exp_iter.push_back(it);
                r.we = 1'b0; r.a = ea(e); r.d = '0;
                exp_log.push_back(r);
                model_v[e] = model_v[e] + 5'd1;
                r.we = 1'b1; r.d = model_v[e];
                exp_log.push_back(r);
            end
        end
    endtask

    task automatic run_start(input bit noise, output int cyc, output int busy_cyc);
        log_q.delete(); out_q.delete(); iter_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; busy_cyc = 0;
        while (!done && cyc < 4000) begin
            if (busy) busy_cyc++;
            if (noise) start = busy ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL run_timeout: no done after %0d cycles, required within 4000", cyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, bus.ram_cs, bus.ram_we, bus.msg_out_valid, bus.msg_in_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {busy, done, bus.ram_cs, bus.ram_we, bus.msg_out_valid, bus.msg_in_ready});
        end
        n_checks++;
        if ({bus.msg_out, bus.ram_data_in, bus.ram_address, edge_idx, iter} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got msg_out=%0d din=%0d addr=%0d edge=%0d iter=%0d, required all 0",
                     bus.msg_out, bus.ram_data_in, bus.ram_address, edge_idx, iter);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_stall();
        int cyc, bcyc, d0, bad;
        bit ok;
        fixed = 1'b0; p_rdy = 100; p_val = 100;
        preload(); build_expect();
        d0 = done_cnt;
        run_start(1'b0, cyc, bcyc);
        n_checks++;
        if (cyc != NE * NI * 5 + 1) begin
            n_fail++; $display("FAIL zs_latency: done after %0d cycles, required %0d", cyc, NE * NI * 5 + 1);
        end
        n_checks++;
        if (bcyc != cyc - 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zs_busy: busy cycles %0d busy_at_done %b, required %0d and 0", bcyc, busy, cyc - 1);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1 || iter !== IW'(NI - 1) || edge_idx !== AW'(NE - 1)) begin
            n_fail++;
            $display("FAIL zs_done_hold: pulses %0d iter %0d edge %0d, required 1 %0d %0d",
                     done_cnt - d0, iter, edge_idx, NI - 1, NE - 1);
        end
        ok = (out_q.size() == exp_out.size()); bad = -1;
        for (int i = 0; ok && i < out_q.size(); i++)
            if (out_q[i] !== exp_out[i] || iter_q[i] != exp_iter[i]) begin ok = 1'b0; bad = i; end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL zs_msg_out: %0d transfers, first bad %0d, required %0d matching", out_q.size(), bad, exp_out.size());
        end
        ok = (log_q.size() == exp_log.size()); bad = -1;
        for (int i = 0; ok && i < log_q.size(); i++)
            if (log_q[i].we !== exp_log[i].we || log_q[i].a !== exp_log[i].a ||
                (exp_log[i].we && log_q[i].d !== exp_log[i].d)) begin ok = 1'b0; bad = i; end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL zs_ram_log: %0d accesses, first bad %0d, required %0d matching", log_q.size(), bad, exp_log.size());
        end
        ok = 1'b1;
        for (int e = 0; e < NE; e++) if (mem[ea(e)] !== model_v[e]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL zs_ram_final: edge0 got %0d, required %0d", mem[ea(0)], model_v[0]);
        end
    endtask

    task automatic test_stall();
        int cyc, bcyc, s0, v0, bad;
        bit ok;
        fixed = 1'b1; rdly = 7; vdly = 3;
        preload(); build_expect();
        s0 = stab_err; v0 = valid_cnt;
        run_start(1'b0, cyc, bcyc);
        @(negedge clk);
        n_checks++;
        if (cyc != NE * NI * 15 + 1) begin
            n_fail++; $display("FAIL st_latency: done after %0d cycles, required %0d", cyc, NE * NI * 15 + 1);
        end
        n_checks++;
        if (stab_err != s0 || valid_cnt - v0 != NE * NI * 8) begin
            n_fail++; $display("FAIL st_hold: unstable %0d valid cycles %0d, required 0 and %0d",
                               stab_err - s0, valid_cnt - v0, NE * NI * 8);
        end
        ok = (log_q.size() == exp_log.size()); bad = -1;
        for (int i = 0; ok && i < log_q.size(); i++)
            if (log_q[i].we !== exp_log[i].we || log_q[i].a !== exp_log[i].a ||
                (exp_log[i].we && log_q[i].d !== exp_log[i].d)) begin ok = 1'b0; bad = i; end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL st_ram_log: %0d accesses, first bad %0d, required %0d matching", log_q.size(), bad, exp_log.size());
        end
        ok = 1'b1;
        for (int e = 0; e < NE; e++) if (mem[ea(e)] !== model_v[e]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL st_ram_final: edge0 got %0d, required %0d", mem[ea(0)], model_v[0]);
        end
        fixed = 1'b0;
    endtask

    task automatic test_random();
        int cyc, bcyc, d0, bad;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            fixed = 1'b0;
            p_rdy = int'($urandom_range(90, 30));
            p_val = int'($urandom_range(90, 30));
            preload(); build_expect();
            d0 = done_cnt;
            run_start(1'b1, cyc, bcyc);
            repeat (2) @(negedge clk);
            n_checks++;
            if (done_cnt - d0 != 1) begin
                n_fail++; $display("FAIL rnd_done[%0d]: %0d pulses, required 1", r, done_cnt - d0);
            end
            ok = (out_q.size() == exp_out.size()); bad = -1;
            for (int i = 0; ok && i < out_q.size(); i++)
                if (out_q[i] !== exp_out[i] || iter_q[i] != exp_iter[i]) begin ok = 1'b0; bad = i; end
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL rnd_msg_out[%0d]: %0d transfers, first bad %0d, required %0d matching", r, out_q.size(), bad, exp_out.size());
            end
            ok = (log_q.size() == exp_log.size()); bad = -1;
            for (int i = 0; ok && i < log_q.size(); i++)
                if (log_q[i].we !== exp_log[i].we || log_q[i].a !== exp_log[i].a ||
                    (exp_log[i].we && log_q[i].d !== exp_log[i].d)) begin ok = 1'b0; bad = i; end
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL rnd_ram_log[%0d]: %0d accesses, first bad %0d, required %0d matching", r, log_q.size(), bad, exp_log.size());
            end
            ok = 1'b1;
            for (int e = 0; e < NE; e++) if (mem[ea(e)] !== model_v[e]) ok = 1'b0;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL rnd_ram_final[%0d]: edge0 got %0d, required %0d", r, mem[ea(0)], model_v[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n, cyc, bcyc, bad;
        bit ok;
        fixed = 1'b0; p_rdy = 100; p_val = 100;
        preload();
        // reset while waiting for the processor on edge 2
        log_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(bus.msg_in_ready && edge_idx == 2 && iter == 0) && n < 200) begin
            @(negedge clk); n++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (n >= 200 || {busy, done, bus.ram_cs, bus.ram_we, bus.msg_out_valid, bus.msg_in_ready} !== 6'b0 ||
            {bus.msg_out, bus.ram_data_in, bus.ram_address, edge_idx, iter} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: wait %0d busy %b cs %b addr %0d edge %0d msg %0d, required all 0",
                     n, busy, bus.ram_cs, bus.ram_address, edge_idx, bus.msg_out);
        end
        ok = (log_q.size() == 5);
        for (int i = 0; ok && i < 5; i++)
            if (log_q[i].we !== 1'(i % 2) || log_q[i].a !== ea(i / 2)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rst_mid_no_write: %0d accesses logged, required R0 W0 R1 W1 R2", log_q.size());
        end
        model_v[0] = model_v[0] + 5'd1;
        model_v[1] = model_v[1] + 5'd1;
        rst = 1'b0;
        // reset sampled in the write cycle of edge 1
        log_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(bus.ram_we && edge_idx == 1) && n < 200) begin
            @(negedge clk); n++;
        end
        rst = 1'b1;
        bad = log_q.size();
        @(negedge clk);
        model_v[0] = model_v[0] + 5'd1;
        ok = 1'b1;
        for (int e = 0; e < NE; e++) if (mem[ea(e)] !== model_v[e]) ok = 1'b0;
        n_checks++;
        if (n >= 200 || log_q.size() != bad || !ok) begin
            n_fail++;
            $display("FAIL rst_wr_suppressed: accesses %0d->%0d edge1 got %0d, required no access and %0d",
                     bad, log_q.size(), mem[ea(1)], model_v[1]);
        end
        rst = 1'b0;
        // a fresh start begins again at edge 0, pass 0
        build_expect();
        run_start(1'b0, cyc, bcyc);
        ok = (out_q.size() == exp_out.size() && log_q.size() == exp_log.size());
        for (int i = 0; ok && i < out_q.size(); i++)
            if (out_q[i] !== exp_out[i] || iter_q[i] != exp_iter[i]) ok = 1'b0;
        for (int i = 0; ok && i < log_q.size(); i++)
            if (log_q[i].we !== exp_log[i].we || log_q[i].a !== exp_log[i].a ||
                (exp_log[i].we && log_q[i].d !== exp_log[i].d)) ok = 1'b0;
        n_checks++;
        if (!ok || cyc != NE * NI * 5 + 1) begin
            n_fail++; $display("FAIL rst_restart: %0d transfers %0d accesses %0d cycles, required %0d %0d %0d",
                               out_q.size(), log_q.size(), cyc, exp_out.size(), exp_log.size(), NE * NI * 5 + 1);
        end
    endtask

`ifdef EXT_INIT_EN
    task automatic test_init();
        int cyc, bcyc, v0;
        bit ok;
        preload();
        init = 1'b1;
        v0 = valid_cnt;
        run_start(1'b0, cyc, bcyc);
        init = 1'b0;
        n_checks++;
        if (cyc != NE + 1 || iter !== '0) begin
            n_fail++; $display("FAIL init_latency: done after %0d cycles iter %0d, required %0d and 0", cyc, iter, NE + 1);
        end
        ok = (log_q.size() == NE);
        for (int i = 0; ok && i < NE; i++)
            if (log_q[i].we !== 1'b1 || log_q[i].a !== ea(i) || log_q[i].d !== '0) ok = 1'b0;
        n_checks++;
        if (!ok || valid_cnt != v0) begin
            n_fail++; $display("FAIL init_writes: %0d accesses %0d valid cycles, required %0d zero writes and 0",
                               log_q.size(), valid_cnt - v0, NE);
        end
        for (int e = 0; e < NE; e++) model_v[e] = '0;
        ok = 1'b1;
        for (int e = 0; e < NE; e++) if (mem[ea(e)] !== model_v[e]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL init_ram_final: edge0 got %0d, required 0", mem[ea(0)]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_stall();
        test_stall();
        test_random();
        test_reset_mid_run();
`ifdef EXT_INIT_EN
        test_init();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
